// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a start/busy/done handshake.
module mul_div_unit #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MD_Start,
    input  logic [DWIDTH-1:0] MD_In_A,
    input  logic [DWIDTH-1:0] MD_In_B,
    input  logic [2:0]        MD_OP,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [DWIDTH-1:0] MD_Out
);

    localparam int unsigned CW = $clog2(DWIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [DWIDTH-1:0] acc, acc_nx;     // product high half / partial remainder
    logic [DWIDTH-1:0] lo, lo_nx;       // multiplier -> product low half / dividend -> quotient
    logic [DWIDTH-1:0] opnd, opnd_nx;   // multiplicand or divisor magnitude
    logic [2:0]        op_q, op_nx;
    logic              a_neg, a_neg_nx;
    logic              b_neg, b_neg_nx;
    logic              pend, pend_nx;   // special-case result parked in lo
    logic              busy_nx, done_nx;
    logic [DWIDTH-1:0] out_nx;

    // Operand sign handling at accept
    logic              a_signed, b_signed, in_a_neg, in_b_neg;
    logic [DWIDTH-1:0] a_mag, b_mag;
    logic              div_zero, div_ovf, is_special;
    logic [DWIDTH-1:0] spec_res;

    assign a_signed = (MD_OP != 3'b011) && (MD_OP != 3'b101) && (MD_OP != 3'b111);
    assign b_signed = a_signed && (MD_OP != 3'b010);
    assign in_a_neg = a_signed && MD_In_A[DWIDTH-1];
    assign in_b_neg = b_signed && MD_In_B[DWIDTH-1];
    assign a_mag    = in_a_neg ? -MD_In_A : MD_In_A;
    assign b_mag    = in_b_neg ? -MD_In_B : MD_In_B;

    assign div_zero   = MD_OP[2] && (MD_In_B == '0);
    assign div_ovf    = MD_OP[2] && !MD_OP[0] && (MD_In_A == MIN_NEG) && (MD_In_B == '1);
    assign is_special = div_zero || div_ovf;
    assign spec_res   = div_zero ? (MD_OP[1] ? MD_In_A : '1)
                                 : (MD_OP[1] ? '0 : MD_In_A);

    // One iteration of each datapath
    logic [DWIDTH:0] mul_sum, div_shift, div_diff;

    assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, lo[DWIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    // Sign correction and result select
    logic [2*DWIDTH-1:0] prod, prod_fix;
    logic [DWIDTH-1:0]   quo_fix, rem_fix, fix_res;

    assign prod     = {acc, lo};
    assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
    assign quo_fix  = (a_neg ^ b_neg) ? -lo : lo;
    assign rem_fix  = a_neg ? -acc : acc;
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q[1:0] == 2'b00) ? prod_fix[DWIDTH-1:0]
                                                      : prod_fix[2*DWIDTH-1:DWIDTH]);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        lo_nx    = lo;
        opnd_nx  = opnd;
        op_nx    = op_q;
        a_neg_nx = a_neg;
        b_neg_nx = b_neg;
        pend_nx  = 1'b0;
        done_nx  = 1'b0;
        out_nx   = MD_Out;

        case (state)
            S_IDLE, S_DONE: begin
                if (MD_Start) begin
                    op_nx    = MD_OP;
                    a_neg_nx = in_a_neg;
                    b_neg_nx = in_b_neg;
                    cnt_nx   = '0;
                    acc_nx   = '0;
                    opnd_nx  = MD_OP[2] ? b_mag : a_mag;
                    if (is_special) begin
                        lo_nx    = spec_res;
                        pend_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        lo_nx    = MD_OP[2] ? a_mag : b_mag;
                        state_nx = S_CALC;
                    end
                end else if (pend) begin
                    done_nx  = 1'b1;
                    out_nx   = lo;
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    if (!div_diff[DWIDTH]) begin
                        acc_nx = div_diff[DWIDTH-1:0];
                        lo_nx  = {lo[DWIDTH-2:0], 1'b1};
                    end else begin
                        acc_nx = div_shift[DWIDTH-1:0];
                        lo_nx  = {lo[DWIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_nx = mul_sum[DWIDTH:1];
                    lo_nx  = {mul_sum[0], lo[DWIDTH-1:1]};
                end
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST_ITER) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                out_nx   = fix_res;
                done_nx  = 1'b1;
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx == S_CALC) || (state_nx == S_FIX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            lo      <= '0;
            opnd    <= '0;
            op_q    <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            pend    <= 1'b0;
            MD_Busy <= 1'b0;
            MD_Done <= 1'b0;
            MD_Out  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            acc     <= acc_nx;
            lo      <= lo_nx;
            opnd    <= opnd_nx;
            op_q    <= op_nx;
            a_neg   <= a_neg_nx;
            b_neg   <= b_neg_nx;
            pend    <= pend_nx;
            MD_Busy <= busy_nx;
            MD_Done <= done_nx;
            MD_Out  <= out_nx;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: RV32M results, latency,
// special cases, handshake and mid-operation reset.
module tb_mul_div_unit;

    localparam int unsigned W = 32;
    localparam int NORM_LAT = 33;
    localparam int SPEC_LAT = 1;

    logic         Clk;
    logic         Reset;
    logic         MD_Start;
    logic [W-1:0] MD_In_A;
    logic [W-1:0] MD_In_B;
    logic [2:0]   MD_OP;
    logic         MD_Busy;
    logic         MD_Done;
    logic [W-1:0] MD_Out;

    int checks;
    int errors;

    mul_div_unit #(.DWIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MD_Start (MD_Start),
        .MD_In_A  (MD_In_A),
        .MD_In_B  (MD_In_B),
        .MD_OP    (MD_OP),
        .MD_Busy  (MD_Busy),
        .MD_Done  (MD_Done),
        .MD_Out   (MD_Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Start one operation, wait for Done and check result, latency and handshake.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int exp_lat, input string name);
        int   lat;
        logic exp_busy;
        logic busy_bad;
        exp_busy = (exp_lat > 1);
        busy_bad = 1'b0;
        lat      = 0;
        MD_OP    = op;
        MD_In_A  = a;
        MD_In_B  = b;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        MD_In_A  = ~a;
        MD_In_B  = ~b;
        MD_OP    = ~op;
        if (MD_Busy !== exp_busy) busy_bad = 1'b1;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge Clk);
            #1;
            if (MD_Done === 1'b1) lat = k;
            else if (MD_Busy !== exp_busy) busy_bad = 1'b1;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (MD_Out !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, MD_Out, exp);
        end
        checks++;
        if (busy_bad !== 1'b0 || MD_Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: profile_bad=%b at_done=%b expected 0/0", name, busy_bad, MD_Busy);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (MD_Done !== 1'b0 || MD_Out !== exp) begin
            errors++;
            $display("FAIL %s hold: done=%b out=%h expected done=0 out=%h", name, MD_Done, MD_Out, exp);
        end
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        MD_Start = 1'b0;
        MD_In_A  = '0;
        MD_In_B  = '0;
        MD_OP    = 3'b000;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (MD_Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b expected 0", MD_Busy);
        end
        checks++;
        if (MD_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b expected 0", MD_Done);
        end
        checks++;
        if (MD_Out !== 32'h0) begin
            errors++;
            $display("FAIL reset out: got %h expected 0", MD_Out);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, NORM_LAT, "mul_7x-3");
        run_op(3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, NORM_LAT, "mulh_7x-3");
        run_op(3'b011, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, NORM_LAT, "mulhu_7xfffffffd");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NORM_LAT, "mulhsu_-1xmax");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, NORM_LAT, "mulh_min_sq");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, NORM_LAT, "div_-7/2");
        run_op(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, NORM_LAT, "rem_-7/2");
        run_op(3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, NORM_LAT, "divu_big/2");
        run_op(3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, NORM_LAT, "remu_big/2");
        run_op(3'b100, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, NORM_LAT, "div_100/-7");
        run_op(3'b110, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, NORM_LAT, "rem_100/-7");
    endtask

    task automatic test_special();
        run_op(3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPEC_LAT, "div_by_zero");
        run_op(3'b111, 32'h00000005, 32'h00000000, 32'h00000005, SPEC_LAT, "remu_by_zero");
        run_op(3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, SPEC_LAT, "divu_by_zero");
        run_op(3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, SPEC_LAT, "rem_by_zero");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT, "div_overflow");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC_LAT, "rem_overflow");
        run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, NORM_LAT, "divu_no_overflow");
    endtask

    task automatic test_ignored_start();
        int lat;
        lat      = 0;
        MD_OP    = 3'b100;
        MD_In_A  = 32'd100;
        MD_In_B  = 32'd7;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge Clk);
            #1;
        end
        MD_In_A  = 32'd50;
        MD_In_B  = 32'd5;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        checks++;
        if (MD_Busy !== 1'b1 || MD_Done !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start state: busy=%b done=%b expected 1/0", MD_Busy, MD_Done);
        end
        for (int k = 7; k <= 200 && lat == 0; k++) begin
            @(posedge Clk);
            #1;
            if (MD_Done === 1'b1) lat = k;
        end
        checks++;
        if (lat !== NORM_LAT) begin
            errors++;
            $display("FAIL ignored_start latency: got %0d expected %0d", lat, NORM_LAT);
        end
        checks++;
        if (MD_Out !== 32'd14) begin
            errors++;
            $display("FAIL ignored_start result: got %h expected %h", MD_Out, 32'd14);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        lat      = 0;
        MD_OP    = 3'b000;
        MD_In_A  = 32'd3;
        MD_In_B  = 32'd5;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge Clk);
            #1;
            if (MD_Done === 1'b1) lat = k;
        end
        checks++;
        if (lat !== NORM_LAT || MD_Out !== 32'd15) begin
            errors++;
            $display("FAIL b2b first: lat=%0d out=%h expected lat=%0d out=%h", lat, MD_Out, NORM_LAT, 32'd15);
        end
        MD_OP    = 3'b101;
        MD_In_A  = 32'd100;
        MD_In_B  = 32'd3;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        checks++;
        if (MD_Done !== 1'b0 || MD_Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: done=%b busy=%b expected 0/1", MD_Done, MD_Busy);
        end
        lat = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(posedge Clk);
            #1;
            if (MD_Done === 1'b1) lat = k;
        end
        checks++;
        if (lat !== NORM_LAT) begin
            errors++;
            $display("FAIL b2b second latency: got %0d expected %0d", lat, NORM_LAT);
        end
        checks++;
        if (MD_Out !== 32'h00000021) begin
            errors++;
            $display("FAIL b2b second result: got %h expected %h", MD_Out, 32'h00000021);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset_mid_calc();
        MD_OP    = 3'b000;
        MD_In_A  = 32'h00001234;
        MD_In_B  = 32'h00000010;
        MD_Start = 1'b1;
        @(posedge Clk);
        #1;
        MD_Start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (MD_Busy !== 1'b0 || MD_Done !== 1'b0 || MD_Out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b out=%h expected 0/0/0", MD_Busy, MD_Done, MD_Out);
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        run_op(3'b000, 32'd3, 32'd4, 32'h0000000C, NORM_LAT, "mul_after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
